// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and load/store, data first with bounded fetch starvation
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_DPRIO = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  logic [3:0] streak;
  logic [1:0] owner;
  always_comb begin
    d_gnt     = !rst && d_req && (!if_req || streak < 4'(MAX_DPRIO));
    if_gnt    = !rst && if_req && !d_gnt;
    mem_en    = if_gnt || d_gnt;
    mem_we    = (d_gnt && d_we) ? d_be : '0;
    mem_addr  = if_gnt ? if_addr : d_addr;
    mem_wdata = d_wdata;
    if_rvalid = owner[1] && !rst;
    d_rvalid  = owner[0] && !rst;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
      owner  <= '0;
    end else begin
      streak <= (d_gnt && if_req) ? streak + 4'd1 : 4'd0;
      owner  <= {if_gnt, d_gnt && !d_we};
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MD = 4;
  logic clk = 0, rst = 1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0] d_be = 0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [3:0] mem_we;
  typedef struct packed { int due; logic port; logic [31:0] data; } exp_t;
  exp_t q[$];
  logic [31:0] ram[16], shadow[16];
  int total = 0, bad = 0, cyc = 0, cnt = 0;
  logic gi, gd;
  logic [9:0] seq;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DPRIO(MD)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[5:2]][b*8+:8] <= mem_wdata[b*8+:8];
      mem_rdata <= ram[mem_addr[5:2]];
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    logic ei, ed;
    ei = 0;
    ed = 0;
    e = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ei = e.port;
      ed = !e.port;
    end
    chk("if_rvalid", if_rvalid, ei);
    chk("d_rvalid", d_rvalid, ed);
    if (ei) chk("if_rdata", if_rdata, e.data);
    if (ed) chk("d_rdata", d_rdata, e.data);
  end
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    logic ed, ei;
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_be = be; d_addr = da; d_wdata = wd;
    if (rst) while (q.size() != 0 && q[0].due <= cyc) void'(q.pop_front());
    #1;
    ed = !rst && dr && (!ir || cnt < MD);
    ei = !rst && ir && !ed;
    chk("d_gnt", d_gnt, ed);
    chk("if_gnt", if_gnt, ei);
    chk("mem_en", mem_en, ed || ei);
    chk("mem_we", mem_we, (ed && dw) ? be : 4'd0);
    if (ei) begin
      chk("mem_addr_i", mem_addr, ia);
      q.push_back('{cyc + 1, 1'b1, shadow[ia[5:2]]});
    end
    if (ed) begin
      chk("mem_addr_d", mem_addr, da);
      chk("mem_wdata", mem_wdata, wd);
      if (!dw) q.push_back('{cyc + 1, 1'b0, shadow[da[5:2]]});
      else for (int b = 0; b < 4; b++) if (be[b]) shadow[da[5:2]][b*8+:8] = wd[b*8+:8];
    end
    cnt = (rst || !(ed && ir)) ? 0 : cnt + 1;
    gi = if_gnt;
    gd = ed;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    logic ip, dp, dw;
    logic [31:0] ia, da, wd;
    logic [3:0] be;
    for (int i = 0; i < 16; i++) begin
      ram[i] = 32'(i * 10);
      shadow[i] = 32'(i * 10);
    end
    @(posedge clk); #1;
    step(1, 32'h8, 1, 0, 0, 32'h4, 0);
    idle();
    rst = 0;
    step(1, 32'h8, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 10; i++) begin
      step(1, 32'hC, 1, 0, 0, 32'h4, 0);
      seq[i] = gi;
    end
    chk("starve_seq", seq, 10'b10000_10000);
    idle();
    step(0, 0, 1, 1, 4'b0011, 32'h10, 32'hAABBCCDD);
    step(0, 0, 1, 0, 0, 32'h10, 0);
    idle();
    step(0, 0, 1, 0, 0, 32'h4, 0);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 32'h4, 0);
    idle();
    step(0, 0, 1, 0, 0, 32'h4, 0);
    rst = 1;
    step(1, 32'h8, 1, 0, 0, 32'h4, 0);
    idle();
    rst = 0;
    step(1, 32'h8, 0, 0, 0, 0, 0);
    idle(); idle(); idle();
    ip = 0; dp = 0; ia = 0; da = 0; wd = 0; be = 0; dw = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!ip) begin
        ip = 1'($urandom_range(0, 1));
        ia = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!dp) begin
        dp = 1'($urandom_range(0, 1));
        da = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        dw = 1'($urandom_range(0, 1));
        be = 4'($urandom);
        wd = $urandom;
      end
      step(ip, ia, dp, dw, be, da, wd);
      if (gi) ip = 0;
      if (gd) dp = 0;
    end
    idle(); idle();
    chk("queue_drained", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
